// File: rtl/sddt_cmd_decoder.sv
// Command-stream consumer: pops 128-bit command words and turns each one into a registered
// DDR4 command, a timed WAIT, a NOP or a dropped illegal word, with status counters.
module sddt_cmd_decoder #(
  parameter int unsigned CMD_WIDTH  = 128,
  parameter int unsigned BG_WIDTH   = 2,
  parameter int unsigned BANK_WIDTH = 2,
  parameter int unsigned ROW_WIDTH  = 17,
  parameter int unsigned COL_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [CMD_WIDTH-1:0]  S_AXIS_CMD_tdata,
  input  logic                  S_AXIS_CMD_tvalid,
  output logic                  S_AXIS_CMD_tready,
  output logic                  ddr_valid,
  input  logic                  ddr_ready,
  output logic                  ddr_act,
  output logic                  ddr_pre,
  output logic                  ddr_pall,
  output logic                  ddr_read,
  output logic                  ddr_write,
  output logic                  ddr_ref,
  output logic                  ddr_ap,
  output logic [BG_WIDTH-1:0]   ddr_bg,
  output logic [BANK_WIDTH-1:0] ddr_bank,
  output logic [ROW_WIDTH-1:0]  ddr_row,
  output logic [COL_WIDTH-1:0]  ddr_col,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            err_opcode,
  output logic [CNT_WIDTH-1:0]  cmd_count
);

  typedef enum logic [1:0] {StIdle, StHold, StWait} state_e;

  localparam logic [7:0] OpAct  = 8'h01;
  localparam logic [7:0] OpPre  = 8'h02;
  localparam logic [7:0] OpPrea = 8'h03;
  localparam logic [7:0] OpRd   = 8'h04;
  localparam logic [7:0] OpWr   = 8'h05;
  localparam logic [7:0] OpRef  = 8'h06;
  localparam logic [7:0] OpWait = 8'h07;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  // Type strobes, bit 0..5 = ACT, PRE, PREA, RD, WR, REF.
  logic [5:0]            type_q, type_d;
  logic                  ap_q, ap_d;
  logic [BG_WIDTH-1:0]   bg_q, bg_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic [31:0]           wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic [7:0]            err_op_q, err_op_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [7:0]  opcode;
  logic [31:0] wait_n;
  logic        is_ddr, is_legal, is_wait, accept;
  logic [5:0]  type_dec;
  logic        unused_tdata;

  assign opcode   = S_AXIS_CMD_tdata[127:120];
  assign wait_n   = S_AXIS_CMD_tdata[31:0];
  assign is_ddr   = (opcode >= OpAct) && (opcode <= OpRef);
  assign is_legal = (opcode <= OpWait);
  assign is_wait  = (opcode == OpWait) && (wait_n != 32'd0);
  // Reserved bits of the command word are deliberately ignored.
  assign unused_tdata = ^S_AXIS_CMD_tdata;

  assign S_AXIS_CMD_tready = (state_q == StIdle) || ((state_q == StHold) && ddr_ready);
  assign accept            = S_AXIS_CMD_tvalid && S_AXIS_CMD_tready;

  always_comb begin
    type_dec = 6'b000000;
    case (opcode)
      OpAct:   type_dec = 6'b000001;
      OpPre:   type_dec = 6'b000010;
      OpPrea:  type_dec = 6'b000100;
      OpRd:    type_dec = 6'b001000;
      OpWr:    type_dec = 6'b010000;
      OpRef:   type_dec = 6'b100000;
      default: type_dec = 6'b000000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    type_d     = type_q;
    ap_d       = ap_q;
    bg_d       = bg_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    err_op_d   = err_op_q;
    count_d    = count_q;

    unique case (state_q)
      StHold: begin
        if (ddr_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
          type_d  = 6'b000000;
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - 32'd1;
        if (wait_cnt_q == 32'd1) state_d = StIdle;
      end
      default: ;
    endcase

    // A new word overrides the drain above, giving back-to-back reloads in HOLD.
    if (accept) begin
      count_d = count_q + 1'b1;
      if (is_ddr) begin
        state_d = StHold;
        valid_d = 1'b1;
        type_d  = type_dec;
        ap_d    = S_AXIS_CMD_tdata[119] && ((opcode == OpRd) || (opcode == OpWr));
        bg_d    = S_AXIS_CMD_tdata[112 +: BG_WIDTH];
        bank_d  = S_AXIS_CMD_tdata[108 +: BANK_WIDTH];
        row_d   = S_AXIS_CMD_tdata[64 +: ROW_WIDTH];
        col_d   = S_AXIS_CMD_tdata[32 +: COL_WIDTH];
      end else if (is_wait) begin
        state_d    = StWait;
        wait_cnt_d = wait_n;
      end else if (!is_legal) begin
        err_d = 1'b1;
        if (!err_q) err_op_d = opcode;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      type_q     <= '0;
      ap_q       <= 1'b0;
      bg_q       <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      err_op_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      type_q     <= type_d;
      ap_q       <= ap_d;
      bg_q       <= bg_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      err_op_q   <= err_op_d;
      count_q    <= count_d;
    end
  end

  assign ddr_valid  = valid_q;
  assign ddr_act    = type_q[0];
  assign ddr_pre    = type_q[1];
  assign ddr_pall   = type_q[2];
  assign ddr_read   = type_q[3];
  assign ddr_write  = type_q[4];
  assign ddr_ref    = type_q[5];
  assign ddr_ap     = ap_q;
  assign ddr_bg     = bg_q;
  assign ddr_bank   = bank_q;
  assign ddr_row    = row_q;
  assign ddr_col    = col_q;
  assign busy       = (state_q != StIdle);
  assign err        = err_q;
  assign err_opcode = err_op_q;
  assign cmd_count  = count_q;

endmodule

// File: doc/sddt_cmd_decoder.md
Name: sddt_cmd_decoder

Overview:
Consumer end of the 128-bit command stream. Pops commands from the master side of the command FIFO (AXI-Stream slave here), decodes each into one DDR4 command or a timed WAIT, and presents it on a registered valid/ready DDR command port toward the scheduler/PHY side. It also reports status: a consumed-command counter, a sticky illegal-opcode flag and a busy bit.

Parameters:
CMD_WIDTH, 128, command word width; fixed layout below
BG_WIDTH, 2, bank-group field width
BANK_WIDTH, 2, bank field width
ROW_WIDTH, 17, row field width
COL_WIDTH, 10, column field width
CNT_WIDTH, 16, consumed-command counter width

Ports:
axi_aclk  in  1  single clock for all logic
axi_aresetn  in  1  asynchronous, active-low reset
S_AXIS_CMD_tdata  in  CMD_WIDTH  command word (from FIFO m_axis_tdata)
S_AXIS_CMD_tvalid  in  1  command valid
S_AXIS_CMD_tready  out  1  decoder accepts word
ddr_valid  out  1  DDR command presented
ddr_ready  in  1  downstream accepts DDR command
ddr_act / ddr_pre / ddr_pall / ddr_read / ddr_write / ddr_ref  out  1 each  one-hot command type, qualified by ddr_valid
ddr_ap  out  1  auto-precharge for RD/WR
ddr_bg  out  BG_WIDTH  bank group
ddr_bank  out  BANK_WIDTH  bank
ddr_row  out  ROW_WIDTH  row (ACT)
ddr_col  out  COL_WIDTH  column (RD/WR)
busy  out  1  output register holds a command, or WAIT is active
err  out  1  sticky: illegal opcode seen
err_opcode  out  8  first illegal opcode captured
cmd_count  out  CNT_WIDTH  words consumed (legal and illegal), wraps

Behaviour:
- Command layout: [127:120] opcode; [119] ap; [115:112] bg (low BG_WIDTH bits used); [111:108] bank (low BANK_WIDTH bits used); [95:64] row (low ROW_WIDTH bits used); [63:32] col (low COL_WIDTH bits used); [31:0] wait cycles. Unused bits are ignored.
- Opcodes: 0x00 NOP, 0x01 ACT, 0x02 PRE, 0x03 PREA (ddr_pall), 0x04 RD, 0x05 WR, 0x06 REF, 0x07 WAIT. Any other value is illegal.
- Reset: all outputs 0, state IDLE, counter 0, err and err_opcode clear. Reset mid-operation discards any held command and any active WAIT count.
- States:
  - IDLE: output register empty.
  - HOLD: ddr_valid=1, command held stable.
  - WAIT: down-counter active.
- S_AXIS_CMD_tready = (state==IDLE) || (state==HOLD && ddr_ready). It is never asserted in WAIT. tready is combinational from state and ddr_ready.
- Accept occurs on tvalid && tready:
  - ACT/PRE/PREA/RD/WR/REF: fields registered; ddr_valid=1 on the next cycle (latency 1); state HOLD.
  - NOP: consumed, no DDR output; state IDLE.
  - WAIT with N=0: consumed as NOP.
  - WAIT with N>0: state WAIT; tready is low for exactly N cycles after the accept cycle, then returns to IDLE.
  - Illegal: consumed and dropped; err set. err_opcode is captured only if err was 0.
- HOLD: all outputs stay stable while ddr_ready=0.
  - On ddr_ready=1 with a new legal DDR-command accept in the same cycle, the output register reloads, keeping back-to-back throughput of 1 command per cycle.
  - Otherwise ddr_valid drops and the next state follows the accepted word as in IDLE, or IDLE if nothing was accepted.
- Type strobes are exactly one-hot while ddr_valid=1 and all 0 otherwise.
- ddr_ap is forced to 0 for non-RD/WR commands. Field outputs hold their last value when ddr_valid=0.
- cmd_count increments once per accepted word and wraps from 2^CNT_WIDTH-1 to 0.
- busy = (state != IDLE).

Test Plan:
- Reset then ACT (bg=1, bank=2, row=0x1ABCD) with ddr_ready=1 -> ddr_valid and ddr_act high one cycle after accept; ddr_bg=1, ddr_bank=2, ddr_row=0x1ABCD; cmd_count=1.
- Stream RD,RD,WR (col 0x10, 0x18, 0x20; ap=1 on WR) with ddr_ready held 1 -> three consecutive ddr_valid cycles with no bubble; ddr_ap=1 only on the WR cycle.
- ACT presented, ddr_ready=0 for 5 cycles -> outputs stable for 5 cycles, tready=0, second queued word not consumed; on ddr_ready=1 the second word is accepted in the same cycle.
- WAIT N=4 followed by PRE -> tready low exactly 4 cycles after the WAIT accept; PRE ddr_valid appears on cycle 6 after the WAIT accept; WAIT N=0 behaves as NOP.
- Opcode 0x5A then 0xFF then REF -> err=1, err_opcode=0x5A, no DDR output for either illegal word, REF issued, cmd_count=3.
- Assert axi_aresetn=0 during HOLD and during WAIT (N=100) -> ddr_valid, busy and err go to 0 immediately; after release, tready=1 and cmd_count=0.
